mmio_timer: RTL and testbench

- Memory-mapped down-counting timer that acts as a bus responder on the processor's data-memory interface (we, a, wd, rd), beside the data memory.
- The processor programs the timer with ordinary load/store word accesses.
- The timer raises a level interrupt when it expires.
- rd is forced to zero when the block is not addressed, so the top level can OR it with the memory read data.

---
 rtl/mmio_timer_pkg.sv | 17 +
 rtl/timer_prescaler.sv | 29 ++
 rtl/mmio_timer.sv | 135 +++++++++++++
 tb/tb_mmio_timer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// mmio_timer shared definitions.
// Word offsets (a[4:2]) and register bit positions.
`timescale 1ns/1ps
package mmio_timer_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer.
// One tick every presc+1 enabled cycles.
`timescale 1ns/1ps
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer.
// Bus responder with sticky expiry flag and level irq.
`timescale 1ns/1ps
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [2:0]         ctrl;
  logic [31:0]        load;
  logic [31:0]        count;
  logic               exp;
  logic [PRESC_W-1:0] presc;

  logic       sel;
  logic [2:0] off;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_count;
  logic       wr_status;
  logic       wr_presc;
  logic       pclr;
  logic       tick;

  logic [31:0] count_nx;
  logic        hw_dis;
  logic        exp_set;
  logic        unused_ok;

  assign sel = (a[31:5] == BASE_ADDR[31:5]);
  assign off = a[4:2];
  assign wr  = we && sel;

  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_load   = wr && (off == OFF_LOAD);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_presc  = wr && (off == OFF_PRESC);

  // restart the prescale period on a fresh enable
  assign pclr = wr_presc
              || (wr_ctrl && !ctrl[CTRL_EN] && wd[CTRL_EN]);

  assign unused_ok = ^{a[1:0], wd};

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (ctrl[CTRL_EN]),
    .clr  (pclr),
    .presc(presc),
    .tick (tick)
  );

  always_comb begin
    count_nx = count;
    hw_dis   = 1'b0;
    exp_set  = 1'b0;
    if (tick) begin
      if (count > 32'd1) begin
        count_nx = count - 32'd1;
      end else if (count == 32'd1) begin
        exp_set = 1'b1;
        if (ctrl[CTRL_AUTO]) begin
          count_nx = load;
        end else begin
          count_nx = '0;
          hw_dis   = 1'b1;
        end
      end else begin
        exp_set = 1'b1;
        hw_dis  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl  <= '0;
      load  <= '0;
      count <= '0;
      exp   <= 1'b0;
      presc <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= wd[2:0];
      end else if (hw_dis) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (wr_load) begin
        load <= wd;
      end
      count <= wr_count ? wd : count_nx;
      // a new expiry outranks a simultaneous clear
      if (exp_set) begin
        exp <= 1'b1;
      end else if (wr_status && wd[STATUS_EXP]) begin
        exp <= 1'b0;
      end
      if (wr_presc) begin
        presc <= wd[PRESC_W-1:0];
      end
    end
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:   rd = {29'd0, ctrl};
        OFF_LOAD:   rd = load;
        OFF_COUNT:  rd = count;
        OFF_STATUS: rd = {31'd0, exp};
        OFF_PRESC:  rd = 32'(presc);
        default:    rd = '0;
      endcase
    end
  end

  assign irq = exp && ctrl[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer.
// Directed scenarios, then random bus traffic vs a model.
`timescale 1ns/1ps
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_count;
  logic        m_exp;
  logic [15:0] m_presc;
  logic [15:0] m_pcnt;

  always #10 clk = ~clk;

  mmio_timer #(
    .BASE_ADDR(BASE),
    .PRESC_W  (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_load;
      3'd2:    return m_count;
      3'd3:    return {31'd0, m_exp};
      3'd4:    return {16'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl  = '0;
    m_load  = '0;
    m_count = '0;
    m_exp   = 1'b0;
    m_presc = '0;
    m_pcnt  = '0;
  endtask

  // One clock edge of the timer, as the register map describes it.
  task automatic model_edge(input logic mwe, input logic [31:0] ma,
                            input logic [31:0] mwd);
    logic        en;
    logic        tk;
    logic [2:0]  n_ctrl;
    logic [31:0] n_load;
    logic [31:0] n_count;
    logic        n_exp;
    logic [15:0] n_presc;
    logic [15:0] n_pcnt;
    logic        expired;
    logic        stop;
    logic        hit;
    en      = m_ctrl[0];
    tk      = en && (m_pcnt == m_presc);
    n_ctrl  = m_ctrl;
    n_load  = m_load;
    n_count = m_count;
    n_presc = m_presc;
    n_pcnt  = (!en || tk) ? 16'd0 : m_pcnt + 16'd1;
    expired = 1'b0;
    stop    = 1'b0;
    if (tk) begin
      if (m_count == 0) begin
        expired = 1'b1;
        stop    = 1'b1;
      end else if (m_count == 1) begin
        expired = 1'b1;
        stop    = !m_ctrl[1];
        n_count = m_ctrl[1] ? m_load : 32'd0;
      end else begin
        n_count = m_count - 1;
      end
    end
    if (stop) n_ctrl[0] = 1'b0;
    n_exp = m_exp;
    hit = mwe && (ma[31:5] == BASE[31:5]);
    if (hit) begin
      case (ma[4:2])
        3'd0: begin
          n_ctrl = mwd[2:0];
          if (!m_ctrl[0] && mwd[0]) n_pcnt = 16'd0;
        end
        3'd1: n_load = mwd;
        3'd2: n_count = mwd;
        3'd3: if (mwd[0]) n_exp = 1'b0;
        3'd4: begin
          n_presc = mwd[15:0];
          n_pcnt  = 16'd0;
        end
        default: ;
      endcase
    end
    if (expired) n_exp = 1'b1;
    m_ctrl  = n_ctrl;
    m_load  = n_load;
    m_count = n_count;
    m_exp   = n_exp;
    m_presc = n_presc;
    m_pcnt  = n_pcnt;
  endtask

  task automatic cyc(input logic w, input logic [31:0] addr,
                     input logic [31:0] data);
    we = w;
    a  = addr;
    wd = data;
    @(posedge clk);
    model_edge(w, addr, data);
    #1;
    we = 1'b0;
    wd = 32'd0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    cyc(1'b1, BASE + {27'd0, off, 2'b00}, d);
  endtask

  task automatic idle();
    cyc(1'b0, BASE, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] off,
                         input logic [31:0] expv);
    we = 1'b0;
    a  = BASE + {27'd0, off, 2'b00};
    #1;
    chk(tag, rd, expv);
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] addr);
    we = 1'b0;
    a  = addr;
    #1;
    chk(tag, rd, 32'd0);
  endtask

  task automatic chk_model();
    for (int i = 0; i < 8; i++) begin
      chk_reg($sformatf("rand_off%0d", i), 3'(i), m_rd(3'(i)));
    end
    chk("rand_irq", {31'd0, irq}, {31'd0, m_ctrl[2] & m_exp});
  endtask

  logic [31:0] seq [6];

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    a     = 32'd0;
    wd    = 32'd0;
    model_reset();
    seq[0] = 2; seq[1] = 1; seq[2] = 3;
    seq[3] = 2; seq[4] = 1; seq[5] = 3;

    // reset state, every offset and outside the window
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk_reg($sformatf("rst_off%0d", i), 3'(i), 32'd0);
    end
    chk_addr("rst_below", BASE - 32'd4);
    chk_addr("rst_above", BASE + 32'h20);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    cyc(1'b1, BASE + 32'h20, 32'hFFFF_FFFF);
    cyc(1'b1, BASE - 32'd4, 32'hFFFF_FFFF);
    cyc(1'b1, BASE ^ 32'h0001_0000, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    chk_reg("out_ctrl", OFF_CTRL, 32'd0);
    chk_reg("out_load", OFF_LOAD, 32'd0);
    chk_reg("out_count", OFF_COUNT, 32'd0);
    chk_reg("out_presc", OFF_PRESC, 32'd0);
    chk_reg("out_off5", 3'd5, 32'd0);

    // auto-reload, period 3 ticks
    wr(OFF_PRESC, 32'd0);
    wr(OFF_LOAD, 32'd3);
    wr(OFF_COUNT, 32'd3);
    wr(OFF_CTRL, 32'd7);
    chk_reg("auto_start", OFF_COUNT, 32'd3);
    for (int k = 0; k < 6; k++) begin
      idle();
      chk_reg($sformatf("auto_cnt%0d", k), OFF_COUNT, seq[k]);
      if (k < 2) begin
        chk_reg("auto_noexp", OFF_STATUS, 32'd0);
        chk("auto_noirq", {31'd0, irq}, 32'd0);
      end else if (k == 2) begin
        chk_reg("auto_exp", OFF_STATUS, 32'd1);
        chk("auto_irq", {31'd0, irq}, 32'd1);
      end
    end

    // one-shot with prescaler 2
    do_reset();
    wr(OFF_PRESC, 32'd2);
    wr(OFF_COUNT, 32'd2);
    wr(OFF_CTRL, 32'd1);
    for (int k = 0; k < 5; k++) idle();
    chk_reg("os_cnt5", OFF_COUNT, 32'd1);
    chk_reg("os_ctrl5", OFF_CTRL, 32'd1);
    chk_reg("os_exp5", OFF_STATUS, 32'd0);
    idle();
    chk_reg("os_cnt6", OFF_COUNT, 32'd0);
    chk_reg("os_ctrl6", OFF_CTRL, 32'd0);
    chk_reg("os_exp6", OFF_STATUS, 32'd1);
    chk("os_irq", {31'd0, irq}, 32'd0);

    // W1C colliding with an expiry
    do_reset();
    wr(OFF_LOAD, 32'd3);
    wr(OFF_COUNT, 32'd1);
    wr(OFF_CTRL, 32'd7);
    wr(OFF_STATUS, 32'd1);
    chk_reg("w1c_race_exp", OFF_STATUS, 32'd1);
    chk_reg("w1c_race_cnt", OFF_COUNT, 32'd3);
    chk("w1c_race_irq", {31'd0, irq}, 32'd1);
    wr(OFF_STATUS, 32'd0);
    chk_reg("w0_noeffect", OFF_STATUS, 32'd1);
    wr(OFF_STATUS, 32'd1);
    chk_reg("w1c_clear", OFF_STATUS, 32'd0);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);

    // COUNT write beats a tick
    do_reset();
    wr(OFF_LOAD, 32'd9);
    wr(OFF_COUNT, 32'd5);
    wr(OFF_CTRL, 32'd3);
    wr(OFF_COUNT, 32'h10);
    chk_reg("cnt_wr_wins", OFF_COUNT, 32'h10);
    wr(OFF_LOAD, 32'd7);
    chk_reg("load_no_cnt", OFF_COUNT, 32'h0F);

    // CTRL write on the one-shot expiry edge
    do_reset();
    wr(OFF_COUNT, 32'd1);
    wr(OFF_CTRL, 32'd1);
    wr(OFF_CTRL, 32'd0);
    chk_reg("ctrl0_en", OFF_CTRL, 32'd0);
    chk_reg("ctrl0_exp", OFF_STATUS, 32'd1);
    do_reset();
    wr(OFF_COUNT, 32'd1);
    wr(OFF_CTRL, 32'd1);
    wr(OFF_CTRL, 32'd1);
    chk_reg("ctrl1_en", OFF_CTRL, 32'd1);
    chk_reg("ctrl1_exp", OFF_STATUS, 32'd1);
    chk_reg("ctrl1_cnt", OFF_COUNT, 32'd0);

    // zero-load guard
    do_reset();
    wr(OFF_CTRL, 32'd3);
    idle();
    chk_reg("zero_exp", OFF_STATUS, 32'd1);
    chk_reg("zero_ctrl", OFF_CTRL, 32'd2);

    // reset mid-count
    wr(OFF_PRESC, 32'd1);
    wr(OFF_LOAD, 32'd5);
    wr(OFF_COUNT, 32'd5);
    wr(OFF_CTRL, 32'd7);
    idle();
    idle();
    chk_reg("mid_cnt", OFF_COUNT, 32'd4);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk_reg($sformatf("mid_rst%0d", i), 3'(i), 32'd0);
    end
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      int r;
      int off;
      logic [31:0] d;
      r = $urandom_range(0, 19);
      if (n % 97 == 96) begin
        do_reset();
      end else if (r < 10) begin
        idle();
      end else if (r == 19) begin
        cyc(1'b1, BASE ^ 32'h0000_0100, $urandom);
      end else begin
        off = $urandom_range(0, 7);
        case (off)
          0:       d = 32'($urandom_range(0, 7));
          1, 2:    d = 32'($urandom_range(0, 5));
          4:       d = 32'($urandom_range(0, 2));
          default: d = $urandom;
        endcase
        wr(3'(off), d);
      end
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
